seg_keyview: RTL
================

Name: seg_keyview

Overview:
- PS/2 scan-code display controller, successor to the two-digit code-to-segment stage.
- Consumes raw PS/2 bytes from the keyboard receiver and parses the E0 and F0 prefixes internally.
- Holds the current key's code on two hex digits and blanks them on release.
- Counts distinct key presses (typematic repeats filtered) on a parametrised BCD counter display.

Parameters:
- CNT_DIGITS, 2, number of decimal digits of the press counter (1..4); counter wraps modulo 10^CNT_DIGITS.
- ACTIVE_LOW, 1, segment polarity; 1 = segment lit by 0.
- BLANK_ON_RELEASE, 1, 1 = code digits blank when the held key is released; 0 = last code stays shown.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- clrn  in  1  asynchronous active-low reset.
- data  in  8  received PS/2 byte.
- data_valid  in  1  one-cycle strobe; data is valid this cycle.
- key_code  out  8  code of the currently held key, 0 when none.
- key_ext  out  1  held key was E0-prefixed.
- key_down  out  1  a key is currently held.
- seg_code  out  16  [7:0] low nibble digit, [15:8] high nibble digit; bit order {dp,g,f,e,d,c,b,a}.
- seg_cnt  out  8*CNT_DIGITS  BCD count digits, [7:0] = units.

Behaviour:
- Reset (clrn=0, asynchronous), all registers cleared:
  - key_code=0, key_ext=0, key_down=0.
  - Prefix flags cleared; count=0.
  - seg_code=blank, i.e. 8'hFF per digit if ACTIVE_LOW, else 8'h00.
  - seg_cnt shows "0" on every digit (8'hC0 each, ACTIVE_LOW).
- Prefix flags ext_pend and brk_pend are updated only on data_valid cycles. The byte is then processed as follows:
  - E0: set ext_pend; nothing else changes.
  - F0: set brk_pend; ext_pend is kept.
  - Any other byte X with brk_pend=0 (make):
    - If key_down and {ext_pend,X}=={key_ext,key_code}: typematic repeat; no change.
    - Otherwise: key_code<=X, key_ext<=ext_pend, key_down<=1, count<=count+1 (BCD, wraps from all-9s to 0).
  - Any other byte X with brk_pend=1 (break):
    - If key_down and {ext_pend,X} matches the held key: key_down<=0. key_code<=0 when BLANK_ON_RELEASE=1; otherwise key_code is kept.
    - Otherwise (release of a non-held key during rollover): no change.
  - After any non-prefix byte, clear both ext_pend and brk_pend.
- FSM view: IDLE (key_down=0) and HELD (key_down=1), with prefix flags orthogonal. Rollover (new make while HELD) stays in HELD and replaces the held key.
- Latency: a byte strobed in cycle N is reflected in key_* and all segment outputs after the edge ending cycle N (one cycle). All outputs are registered.
- Segment digits from code:
  - While key_down=1, digits show hex nibbles of key_code.
  - While key_down=0 and BLANK_ON_RELEASE=1, both digits are blank.
  - While key_down=0 and BLANK_ON_RELEASE=0, digits show the last code.
- Hex decode (ACTIVE_LOW, dp off): 0 C0, 1 F9, 2 A4, 3 B0, 4 99, 5 92, 6 82, 7 F8, 8 80, 9 90, A 88, b 83, C C6, d A1, E 86, F 8E. When ACTIVE_LOW=0, every pattern is bitwise inverted.
- Count digits always show BCD values 0..9 with no leading-zero blanking.
- Edge cases:
  - data_valid=0: the data byte is ignored.
  - Consecutive prefixes: E0 E0 behaves as a single E0; F0 F0 behaves as a single F0.
  - E1 (Pause) is out of scope and is treated as an ordinary make code.
  - Reset mid-sequence discards pending prefixes. A subsequent bare break byte is then treated as a make.

Test Plan:
- Reset, then strobe 1C: key_code=1C, key_down=1, seg_code={F9 (1), C6 (C)}; count digits read "01" (seg_cnt=16'hC0F9).
- 1C repeated 5 times, then F0 1C: count stays 1; after the release key_down=0 and seg_code=16'hFFFF.
- E0 75, then F0 75: the non-ext release is ignored (key_down stays 1, key_ext=1); then E0 F0 75 releases the key.
- Rollover: 1C, 32, F0 1C: key_code stays 32 and key_down stays 1; count=2.
- 99 distinct makes (alternating 1C and 32, with releases) then one more make: count wraps 99 → 00, displayed as seg_cnt=16'hC0C0.
- Issue E0 F0, assert clrn low for 3 cycles mid-sequence, then strobe 1C: treated as a make; all outputs equal their reset values while clrn is low.

Source files
------------

// File: rtl/seg_keyview.sv
// PS/2 key viewer: parses E0/F0 prefixes from raw bytes, shows the held key code on
// two hex digits and counts distinct key presses on a BCD segment display.
module seg_keyview #(
  parameter int CNT_DIGITS       = 2,
  parameter bit ACTIVE_LOW       = 1'b1,
  parameter bit BLANK_ON_RELEASE = 1'b1
) (
  input  logic                    clk,
  input  logic                    clrn,
  input  logic [7:0]              data,
  input  logic                    data_valid,
  output logic [7:0]              key_code,
  output logic                    key_ext,
  output logic                    key_down,
  output logic [15:0]             seg_code,
  output logic [8*CNT_DIGITS-1:0] seg_cnt
);

  typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_HELD = 1'b1} state_t;

  localparam logic [7:0] SEG_BLANK = ACTIVE_LOW ? 8'hFF : 8'h00;

  // Hex digit to {dp,g,f,e,d,c,b,a}, polarity applied.
  function automatic logic [7:0] hex_seg(input logic [3:0] nib);
    logic [7:0] pat;
    case (nib)
      4'h0: pat = 8'hC0;
      4'h1: pat = 8'hF9;
      4'h2: pat = 8'hA4;
      4'h3: pat = 8'hB0;
      4'h4: pat = 8'h99;
      4'h5: pat = 8'h92;
      4'h6: pat = 8'h82;
      4'h7: pat = 8'hF8;
      4'h8: pat = 8'h80;
      4'h9: pat = 8'h90;
      4'hA: pat = 8'h88;
      4'hB: pat = 8'h83;
      4'hC: pat = 8'hC6;
      4'hD: pat = 8'hA1;
      4'hE: pat = 8'h86;
      4'hF: pat = 8'h8E;
      default: pat = 8'hFF;
    endcase
    hex_seg = ACTIVE_LOW ? pat : ~pat;
  endfunction

  state_t                    r_state, w_state_nxt;
  logic [7:0]                r_key_code, w_key_code_nxt;
  logic                      r_key_ext, w_key_ext_nxt;
  logic                      r_ext_pend, w_ext_pend_nxt;
  logic                      r_brk_pend, w_brk_pend_nxt;
  logic [4*CNT_DIGITS-1:0]   r_cnt, w_cnt_nxt, w_cnt_inc;
  logic [15:0]               r_seg_code, w_seg_code_nxt;
  logic [8*CNT_DIGITS-1:0]   r_seg_cnt, w_seg_cnt_nxt, w_seg_cnt_rst;
  logic                      w_match;
  logic                      w_carry;

  assign w_match = (r_state == ST_HELD) && ({r_ext_pend, data} == {r_key_ext, r_key_code});

  // BCD increment with ripple carry; all-9s wraps to zero.
  always_comb begin
    w_cnt_inc = r_cnt;
    w_carry   = 1'b1;
    for (int i = 0; i < CNT_DIGITS; i++) begin
      if (w_carry) begin
        if (r_cnt[4*i +: 4] == 4'd9) begin
          w_cnt_inc[4*i +: 4] = 4'd0;
        end else begin
          w_cnt_inc[4*i +: 4] = r_cnt[4*i +: 4] + 4'd1;
          w_carry = 1'b0;
        end
      end else begin
        w_cnt_inc[4*i +: 4] = r_cnt[4*i +: 4];
      end
    end
  end

  // Byte parser and IDLE/HELD next-state logic.
  always_comb begin
    w_state_nxt    = r_state;
    w_key_code_nxt = r_key_code;
    w_key_ext_nxt  = r_key_ext;
    w_ext_pend_nxt = r_ext_pend;
    w_brk_pend_nxt = r_brk_pend;
    w_cnt_nxt      = r_cnt;
    if (data_valid) begin
      if (data == 8'hE0) begin
        w_ext_pend_nxt = 1'b1;
      end else if (data == 8'hF0) begin
        w_brk_pend_nxt = 1'b1;
      end else begin
        w_ext_pend_nxt = 1'b0;
        w_brk_pend_nxt = 1'b0;
        if (!r_brk_pend) begin
          // A matching make while held is typematic repeat and is dropped.
          if (!w_match) begin
            w_key_code_nxt = data;
            w_key_ext_nxt  = r_ext_pend;
            w_state_nxt    = ST_HELD;
            w_cnt_nxt      = w_cnt_inc;
          end else begin
            w_state_nxt = r_state;
          end
        end else begin
          if (w_match) begin
            w_state_nxt = ST_IDLE;
            if (BLANK_ON_RELEASE) begin
              w_key_code_nxt = 8'h00;
            end else begin
              w_key_code_nxt = r_key_code;
            end
          end else begin
            w_state_nxt = r_state;
          end
        end
      end
    end else begin
      w_state_nxt = r_state;
    end
  end

  // Segment images computed from next state so they land on the same edge.
  always_comb begin
    w_seg_code_nxt = {SEG_BLANK, SEG_BLANK};
    if (BLANK_ON_RELEASE && (w_state_nxt == ST_IDLE)) begin
      w_seg_code_nxt = {SEG_BLANK, SEG_BLANK};
    end else begin
      w_seg_code_nxt = {hex_seg(w_key_code_nxt[7:4]), hex_seg(w_key_code_nxt[3:0])};
    end
    w_seg_cnt_nxt = '0;
    w_seg_cnt_rst = '0;
    for (int i = 0; i < CNT_DIGITS; i++) begin
      w_seg_cnt_nxt[8*i +: 8] = hex_seg(w_cnt_nxt[4*i +: 4]);
      w_seg_cnt_rst[8*i +: 8] = hex_seg(4'h0);
    end
  end

  // State and registered output images.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      r_state    <= ST_IDLE;
      r_key_code <= 8'h00;
      r_key_ext  <= 1'b0;
      r_ext_pend <= 1'b0;
      r_brk_pend <= 1'b0;
      r_cnt      <= '0;
      r_seg_code <= {SEG_BLANK, SEG_BLANK};
      r_seg_cnt  <= w_seg_cnt_rst;
    end else begin
      r_state    <= w_state_nxt;
      r_key_code <= w_key_code_nxt;
      r_key_ext  <= w_key_ext_nxt;
      r_ext_pend <= w_ext_pend_nxt;
      r_brk_pend <= w_brk_pend_nxt;
      r_cnt      <= w_cnt_nxt;
      r_seg_code <= w_seg_code_nxt;
      r_seg_cnt  <= w_seg_cnt_nxt;
    end
  end

  assign key_code = r_key_code;
  assign key_ext  = r_key_ext;
  assign key_down = (r_state == ST_HELD);
  assign seg_code = r_seg_code;
  assign seg_cnt  = r_seg_cnt;

endmodule
